ysyx_22041752_trap_ctrl: RTL
============================

Name: ysyx_22041752_trap_ctrl

Overview:
Trap-entry/exit sequencer that sits directly upstream of the CSR file and owns its single read/write port (wen/addr/wdata/rdata). It accepts an ecall-style exception, the timer interrupt (the CSR file's int_t_o) or an mret from the pipeline. It then runs a multi-cycle write/read sequence on mepc, mcause, mstatus, mtvec and returns one redirect PC to fetch. The pipeline stalls while busy is high.

Parameters:
XLEN, 64, data width of CSRs and PCs
INT_T_CAUSE, 64'h8000_0000_0000_0007, mcause value written for a machine timer interrupt

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
int_t  in  1  timer interrupt pending (CSR file int_t_o)
int_pc  in  XLEN  PC to resume at after an interrupt
exc_valid  in  1  synchronous exception request (ecall)
exc_pc  in  XLEN  PC of the faulting instruction
exc_cause  in  XLEN  mcause value for the exception
mret_valid  in  1  mret request
busy  out  1  sequence in progress; pipeline must stall
csr_wen  out  1  CSR write enable
csr_addr  out  12  CSR address (read and write)
csr_wdata  out  XLEN  CSR write data
csr_rdata  in  XLEN  combinational CSR read data for csr_addr
redirect_valid  out  1  one-cycle pulse: fetch jumps to redirect_pc
redirect_pc  out  XLEN  target PC, held until next redirect

Behaviour:
- Clock is clk; reset is resetn, asynchronous and active-low. The one-hot/encoded state and all registers clear immediately when resetn goes low.
- Reset values: state=IDLE, busy=0, csr_wen=0, csr_addr=12'h000, csr_wdata=0, redirect_valid=0, redirect_pc=0, internal epc/cause latches=0.
- CSR addresses: mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342.
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, R_STATUS, R_EPC, REDIR.
- busy = (state != IDLE). csr_* and redirect_valid are Moore outputs of the state. csr_wdata for T_STATUS/R_STATUS is derived combinationally from csr_rdata.
- IDLE: requests are sampled only here. Priority when several are asserted in the same cycle: int_t > exc_valid > mret_valid.
  - Interrupt: latch epc=int_pc and cause=INT_T_CAUSE, then go to T_EPC.
  - Exception: latch epc=exc_pc and cause=exc_cause, then go to T_EPC.
  - mret: go to R_STATUS.
  - No request: stay in IDLE.
  - csr_wen=0 and csr_addr=0 in IDLE.
- T_EPC: wen=1, addr=mepc, wdata=epc. Next state T_CAUSE.
- T_CAUSE: wen=1, addr=mcause, wdata=cause. Next state T_STATUS.
- T_STATUS: wen=1, addr=mstatus. wdata=rdata with bit7 (MPIE) = rdata[3], bit3 (MIE) = 0, bits[12:11] (MPP) = 2'b11, all other bits unchanged. Next state T_VEC.
- T_VEC: wen=0, addr=mtvec. Latch target = {rdata[XLEN-1:2],2'b00}. Next state REDIR.
- R_STATUS: wen=1, addr=mstatus. wdata=rdata with bit3 = rdata[7], bit7 = 1, MPP = 2'b11. Next state R_EPC.
- R_EPC: wen=0, addr=mepc. Latch target = rdata. Next state REDIR.
- REDIR: redirect_valid=1, redirect_pc=target, wen=0. Next state IDLE.
- Latency from the sampling edge:
  - Trap: redirect_valid high in the 5th cycle; busy high for 5 cycles.
  - mret: redirect_valid high in the 3rd cycle; busy high for 3 cycles.
- Requests arriving while busy are ignored and not queued; the pipeline is stalled, so they re-present themselves.
- int_t deasserting mid-sequence has no effect; the sequence completes.
- Back-to-back: a request present in the first IDLE cycle after REDIR is accepted, with no dead cycle.
- Reset mid-sequence: the state returns to IDLE immediately. Partial CSR writes already performed are not undone, and no redirect is issued.

Optional Feature:
Macro YSYX_22041752_TRAP_VEC_EN.
- Defined: in T_VEC, if rdata[1:0]==2'b01 and cause[XLEN-1]==1, target = {rdata[XLEN-1:2],2'b00} + (cause[XLEN-2:0] << 2). Exceptions still use base only.
- Undefined: mtvec is always treated as direct mode and the mode bits are ignored.

Test Plan:
1. mstatus=64'ha00001808, mtvec=64'h80000100, exc_valid=1 with exc_pc=64'h80000040 and exc_cause=11 -> mepc=64'h80000040, mcause=11, mstatus=64'ha00001880; redirect_valid in cycle 5 with redirect_pc=64'h80000100; busy high for 5 cycles.
2. Same as 1 but int_t=1, int_pc=64'h80000044, also with exc_valid=1 -> interrupt wins; mcause=64'h8000000000000007, mepc=64'h80000044.
3. mstatus=64'ha00001880, mepc=64'h80000044, mret_valid=1 -> mstatus=64'ha00001888; redirect_pc=64'h80000044 in cycle 3.
4. mtvec=64'h80000101 with an interrupt -> macro on: redirect_pc=64'h8000011C; macro off: 64'h80000100.
5. Assert exc_valid, then pull resetn low during T_CAUSE -> busy=0 and all outputs 0 immediately; redirect_valid never pulses; after release the block sits in IDLE.
6. Assert mret_valid in the cycle right after REDIR of a trap -> accepted with no gap; a second request held during busy causes no extra sequence.

Source files
------------

// File: rtl/ysyx_22041752_trap_ctrl.sv
// Trap entry/exit sequencer that owns the CSR file's single read/write port.
// Optional vectored mtvec for interrupts: define YSYX_22041752_TRAP_VEC_EN.
module ysyx_22041752_trap_ctrl #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] INT_T_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            int_t,
    input  logic [XLEN-1:0] int_pc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_cause,
    input  logic            mret_valid,
    output logic            busy,
    output logic            csr_wen,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    typedef enum logic [2:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTStatus,
        StTVec,
        StRStatus,
        StREpc,
        StRedir
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0] status_trap;
    logic [XLEN-1:0] status_mret;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;

    // mstatus rewrite on trap entry (MIE -> MPIE, MIE cleared) and on mret (MPIE -> MIE).
    always_comb begin
        status_trap        = csr_rdata;
        status_trap[7]     = csr_rdata[3];
        status_trap[3]     = 1'b0;
        status_trap[12:11] = 2'b11;
        status_mret        = csr_rdata;
        status_mret[3]     = csr_rdata[7];
        status_mret[7]     = 1'b1;
        status_mret[12:11] = 2'b11;
    end

    assign vec_base = {csr_rdata[XLEN-1:2], 2'b00};

`ifdef YSYX_22041752_TRAP_VEC_EN
    // Vectored mode only offsets interrupts; exceptions land on the base.
    assign vec_target = (csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1])
                      ? vec_base + {cause_q[XLEN-3:0], 2'b00}
                      : vec_base;
`else
    assign vec_target = vec_base;
`endif

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        target_d      = target_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (int_t) begin
                    epc_d   = int_pc;
                    cause_d = INT_T_CAUSE;
                    state_d = StTEpc;
                end else if (exc_valid) begin
                    epc_d   = exc_pc;
                    cause_d = exc_cause;
                    state_d = StTEpc;
                end else if (mret_valid) begin
                    state_d = StRStatus;
                end
            end
            StTEpc:    state_d = StTCause;
            StTCause:  state_d = StTStatus;
            StTStatus: state_d = StTVec;
            StTVec: begin
                target_d = vec_target;
                state_d  = StRedir;
            end
            StRStatus: state_d = StREpc;
            StREpc: begin
                target_d = csr_rdata;
                state_d  = StRedir;
            end
            StRedir: begin
                redirect_pc_d = target_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            epc_q         <= '0;
            cause_q       <= '0;
            target_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            target_q      <= target_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        csr_wen        = 1'b0;
        csr_addr       = 12'h000;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        unique case (state_q)
            StTEpc: begin
                csr_wen   = 1'b1;
                csr_addr  = CsrMepc;
                csr_wdata = epc_q;
            end
            StTCause: begin
                csr_wen   = 1'b1;
                csr_addr  = CsrMcause;
                csr_wdata = cause_q;
            end
            StTStatus: begin
                csr_wen   = 1'b1;
                csr_addr  = CsrMstatus;
                csr_wdata = status_trap;
            end
            StTVec:    csr_addr = CsrMtvec;
            StRStatus: begin
                csr_wen   = 1'b1;
                csr_addr  = CsrMstatus;
                csr_wdata = status_mret;
            end
            StREpc:    csr_addr = CsrMepc;
            StRedir:   redirect_valid = 1'b1;
            default:   csr_wen = 1'b0;
        endcase
    end

    assign busy = (state_q != StIdle);
    // Present the new target during the pulse, then hold it until the next redirect.
    assign redirect_pc = (state_q == StRedir) ? target_q : redirect_pc_q;

endmodule
